// File: rtl/uart_rx_if.sv
// Serial-line and byte-output bundle for the uart_rx receive path.
// The slave modport is the receiver; the master modport is the line driver / byte consumer.
interface uart_rx_if;
  logic       i_RX;
  logic [7:0] o_DATA;
  logic       o_RX_DONE;
  logic       o_FRAME_ERR;

  modport master (
    output i_RX,
    input  o_DATA,
    input  o_RX_DONE,
    input  o_FRAME_ERR
  );

  modport slave (
    input  i_RX,
    output o_DATA,
    output o_RX_DONE,
    output o_FRAME_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit oversampling FSM,
// registered byte output with one-cycle done / framing-error strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic     i_CLK,
  input  logic     i_RST_N,
  uart_rx_if.slave bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  logic          rx_s;
  state_t        state_r,  state_nxt_s;
  logic [CW-1:0] cnt_r,    cnt_nxt_s;
  logic [3:0]    bit_r,    bit_nxt_s;
  logic [7:0]    shift_r,  shift_nxt_s;
  logic [7:0]    data_r,   data_nxt_s;
  logic          done_r,   done_nxt_s;
  logic          ferr_r,   ferr_nxt_s;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.i_RX;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s = sync2_r;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= 4'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      done_r  <= done_nxt_s;
      ferr_r  <= ferr_nxt_s;
    end
  end

  // Next-state logic; strobes default low so they last exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = data_r;
    done_nxt_s  = 1'b0;
    ferr_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt_s = START;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r != CNT_HALF) begin
          cnt_nxt_s = cnt_r + CW'(1);
        end else if (!rx_s) begin
          state_nxt_s = DATA;
          cnt_nxt_s   = '0;
          bit_nxt_s   = 4'd0;
        end else begin
          // Start bit gone high by mid-bit: treat as a glitch.
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      end
      DATA: begin
        if (cnt_r != CNT_LAST) begin
          cnt_nxt_s = cnt_r + CW'(1);
        end else begin
          shift_nxt_s = {rx_s, shift_r[7:1]};
          bit_nxt_s   = bit_r + 4'd1;
          cnt_nxt_s   = '0;
          if (bit_r == 4'd7) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end
      end
      STOP: begin
        if (cnt_r != CNT_LAST) begin
          cnt_nxt_s = cnt_r + CW'(1);
        end else begin
          if (rx_s) begin
            data_nxt_s = shift_r;
            done_nxt_s = 1'b1;
          end else begin
            ferr_nxt_s = 1'b1;
          end
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign bus.o_DATA      = data_r;
  assign bus.o_RX_DONE   = done_r;
  assign bus.o_FRAME_ERR = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected pulses
// (kind, cycle, byte) are queued at drive time and checked when the DUT strobes.
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
  localparam int PULSE_LAT = 3 + HALF + 9 * CPB;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic i_CLK;
  logic i_RST_N;
  int   cyc;
  int   checks;
  int   errors;
  logic [7:0] last_good;
  exp_t q[$];

  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .bus     (bus_if)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  initial cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame starting just after a falling edge; queue the pulse it should cause.
  task automatic send(input logic [7:0] b, input logic stop);
    exp_t e;
    e.err  = ~stop;
    e.data = stop ? b : last_good;
    e.cyc  = cyc + PULSE_LAT;
    q.push_back(e);
    if (stop) last_good = b;
    bus_if.i_RX = 1'b0;
    repeat (CPB) @(negedge i_CLK);
    for (int i = 0; i < 8; i++) begin
      bus_if.i_RX = b[i];
      repeat (CPB) @(negedge i_CLK);
    end
    bus_if.i_RX = stop;
    repeat (CPB) @(negedge i_CLK);
  endtask

  // Scoreboard: every strobe must match the head of the expectation queue.
  always @(negedge i_CLK) begin
    exp_t e;
    if (bus_if.o_RX_DONE === 1'b1 || bus_if.o_FRAME_ERR === 1'b1) begin
      check("done_and_err_exclusive", 32'(bus_if.o_RX_DONE & bus_if.o_FRAME_ERR), 32'd0);
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed done=%0b err=%0b expected none at cyc %0d",
               bus_if.o_RX_DONE, bus_if.o_FRAME_ERR, cyc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pulse_kind_err", 32'(bus_if.o_FRAME_ERR), 32'(e.err));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_data", 32'(bus_if.o_DATA), 32'(e.data));
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    last_good    = 8'h00;
    i_RST_N      = 1'b0;
    bus_if.i_RX  = 1'b1;
    repeat (2) @(negedge i_CLK);
    i_RST_N = 1'b1;

    // Idle line after reset
    repeat (20) @(negedge i_CLK);
    check("reset_data", 32'(bus_if.o_DATA), 32'h00);
    check("reset_done", 32'(bus_if.o_RX_DONE), 32'd0);
    check("reset_ferr", 32'(bus_if.o_FRAME_ERR), 32'd0);

    // Good frame 0xA5
    send(8'hA5, 1'b1);
    repeat (5) @(negedge i_CLK);
    check("a5_pending", 32'(q.size()), 32'd0);
    check("a5_data", 32'(bus_if.o_DATA), 32'hA5);

    // One-cycle low glitch while idle
    bus_if.i_RX = 1'b0;
    @(negedge i_CLK);
    bus_if.i_RX = 1'b1;
    repeat (12) @(negedge i_CLK);
    check("glitch_data", 32'(bus_if.o_DATA), 32'hA5);
    check("glitch_pending", 32'(q.size()), 32'd0);

    // Framing error: 0x3C with stop bit low
    send(8'h3C, 1'b0);
    bus_if.i_RX = 1'b1;
    repeat (5) @(negedge i_CLK);
    check("ferr_pending", 32'(q.size()), 32'd0);
    check("ferr_data_kept", 32'(bus_if.o_DATA), 32'hA5);

    // Back-to-back 0x00 then 0xFF
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    repeat (5) @(negedge i_CLK);
    check("b2b_pending", 32'(q.size()), 32'd0);
    check("b2b_data", 32'(bus_if.o_DATA), 32'hFF);

    // Reset during data bit 4 of a 0x5A frame
    bus_if.i_RX = 1'b0;
    repeat (CPB) @(negedge i_CLK);
    for (int i = 0; i < 3; i++) begin
      bus_if.i_RX = (i == 1);
      repeat (CPB) @(negedge i_CLK);
    end
    bus_if.i_RX = 1'b1;
    repeat (2) @(negedge i_CLK);
    i_RST_N = 1'b0;
    @(negedge i_CLK);
    i_RST_N   = 1'b1;
    last_good = 8'h00;
    check("rst_mid_data", 32'(bus_if.o_DATA), 32'h00);
    repeat (60) @(negedge i_CLK);
    check("rst_mid_data_later", 32'(bus_if.o_DATA), 32'h00);
    check("rst_mid_pending", 32'(q.size()), 32'd0);

    // Clean 0x5A after the aborted frame
    send(8'h5A, 1'b1);
    repeat (5) @(negedge i_CLK);
    check("5a_pending", 32'(q.size()), 32'd0);
    check("5a_data", 32'(bus_if.o_DATA), 32'h5A);
    repeat (20) @(negedge i_CLK);
    check("5a_data_held", 32'(bus_if.o_DATA), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receive path: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Synchronises the asynchronous serial line into the i_CLK domain and oversamples each bit CLKS_PER_BIT times, taking one sample at mid-bit.
- Delivers each received byte with a one-cycle done strobe, or flags a framing error.
- Sits between the pad-level RX pin and byte-oriented consumer logic (FIFO or register interface).

Parameters:
- CLKS_PER_BIT, 4, i_CLK cycles per serial bit. Legal values are 2 and above. HALF = CLKS_PER_BIT/2, using integer division.

Ports:
- i_CLK  input  1  system clock; all logic updates on its rising edge.
- i_RST_N  input  1  reset. One clock; reset is synchronous and active-low.
- i_RX  input  1  asynchronous serial line; idles high.
- o_DATA  output  8  last correctly framed byte; held until the next good frame.
- o_RX_DONE  output  1  one-cycle pulse when o_DATA is updated.
- o_FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (i_RST_N=0 at a rising edge):
  - state=IDLE, bit count=0, cycle counter=0, shift register=0x00.
  - o_DATA=0x00, o_RX_DONE=0, o_FRAME_ERR=0.
  - Both synchroniser flops are set to 1 (line idle).
  - Reset overrides everything, including mid-frame; any partial frame is discarded.
- Synchroniser: i_RX passes through two flops; rx_s is the second flop's output. All FSM decisions use rx_s only.
- State register is 2 bits: IDLE=00, START=01, DATA=10, STOP=11.
- IDLE:
  - If rx_s=0: go to START, counter=0.
  - Otherwise stay in IDLE.
- START:
  - If counter != HALF-1: increment counter.
  - Else if rx_s=0: go to DATA, counter=0, bit count=0.
  - Else the start bit was a glitch: return to IDLE with no outputs.
- DATA:
  - If counter != CLKS_PER_BIT-1: increment counter.
  - Else: shift right with the new bit entering bit 7 (shift = {rx_s, shift[7:1]}), bit count +1, counter=0.
  - When the 8th bit has been taken (bit count reaches 8): go to STOP.
  - Bit count is 4 bits wide and never exceeds 8.
- STOP:
  - If counter != CLKS_PER_BIT-1: increment counter.
  - Else if rx_s=1: o_DATA <= shift register, o_RX_DONE=1 for exactly one cycle.
  - Else: o_FRAME_ERR=1 for exactly one cycle; o_DATA unchanged.
  - Either way, go to IDLE with counter=0.
- o_RX_DONE and o_FRAME_ERR are registered, are 0 in every other cycle, and are never high together.
- Latency: let edge j be the first rising edge that samples i_RX=0.
  - IDLE sees rx_s=0 at edge j+2.
  - The start check happens at edge j+2+HALF.
  - Data bit n (n=1..8) is sampled at edge j+2+HALF+n*CLKS_PER_BIT.
  - The stop bit is sampled at edge j+2+HALF+9*CLKS_PER_BIT, and o_RX_DONE is high in the cycle that follows.
  - With CLKS_PER_BIT=4 this is edge j+40.
- Back-to-back frames: IDLE is reached in the same cycle the done/error pulse is issued. A start bit that immediately follows the stop bit is accepted with no lost cycles.
- Line held low (break):
  - A framing error is reported.
  - The FSM then re-enters START while rx_s stays 0, producing one framing error per frame period until the line returns high.
- A new start edge arriving while a frame is in progress is ignored; there is no resynchronisation mid-frame.
- o_DATA is never modified outside a good stop-bit sample.

Test Plan:
- Reset, then idle-high line for 20 cycles -> o_DATA=0x00, no o_RX_DONE and no o_FRAME_ERR pulses.
- CLKS_PER_BIT=4, send 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) starting at edge j -> o_RX_DONE high exactly one cycle after edge j+40, o_DATA=0xA5, o_FRAME_ERR never asserts.
- Low glitch of 1 cycle on i_RX while idle -> FSM returns to IDLE, no done/error pulse, o_DATA keeps its previous value.
- Send 0x3C with the stop bit forced low -> o_FRAME_ERR one-cycle pulse at the stop sample, o_DATA retains the prior byte, o_RX_DONE stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two o_RX_DONE pulses exactly 10*CLKS_PER_BIT cycles apart, o_DATA=0x00 then 0xFF.
- Assert i_RST_N=0 for one edge during data bit 4 of a frame -> all state returns to reset values, no pulse for the aborted frame. Then send a clean 0x5A -> o_DATA=0x5A with a single o_RX_DONE pulse.
